// File: rtl/cmd_frame_tx.sv
// -----------------------------------------------------------------------------
// cmd_frame_tx
//
// Turns one command into a short burst of UART frames on tx_out. Each command
// type maps to a fixed byte sequence (opcode byte followed by 1..3 payload
// bytes). Every byte is sent as start bit, 8 data bits LSB first, an optional
// parity bit and a stop bit, each lasting P clock cycles, with no idle gap
// between the bytes of one command.
//
// Ports
//   CLK            clock, rising edge
//   RST            asynchronous active-low reset
//   cmd_valid      command presented
//   cmd_ready      command can be accepted (== !busy)
//   cmd_type       0=RF write, 1=RF read, 2=ALU with operands, 3=ALU no operands
//   cmd_addr       register file address
//   cmd_data0      RF write data or operand A
//   cmd_data1      operand B
//   cmd_fun        ALU function code
//   parity_enable  insert a parity bit after the data bits
//   parity_type    0=even, 1=odd
//   prescale       CLK cycles per serial bit (values below 4 act as 4)
//   tx_out         registered serial line, idles high
//   busy           a frame is in flight
//   done           one-cycle pulse after the last stop bit
// -----------------------------------------------------------------------------
module cmd_frame_tx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data0,
  input  logic [7:0] cmd_data1,
  input  logic [3:0] cmd_fun,
  input  logic       parity_enable,
  input  logic       parity_type,
  input  logic [5:0] prescale,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OPS = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  localparam logic [5:0] MIN_PRESCALE = 6'd4;

  // FSM and counters
  state_e     state_q, state_d;
  logic [5:0] pcnt_q, pcnt_d;    // cycles elapsed inside the current bit
  logic [3:0] bit_q, bit_d;      // data bit index inside the current byte
  logic [1:0] byte_q, byte_d;    // byte index inside the command sequence
  logic       done_q, done_d;
  logic       tx_q, tx_d;

  // Command fields captured at acceptance
  cmd_type_e  type_q;
  logic [3:0] addr_q;
  logic [7:0] data0_q;
  logic [7:0] data1_q;
  logic [3:0] fun_q;
  logic       par_en_q;
  logic       par_odd_q;
  logic [5:0] prescale_q;

  logic       accept;
  logic [5:0] p_eff;
  logic       bit_end;
  logic [1:0] last_byte;
  logic [7:0] byte_val;

  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign tx_out    = tx_q;
  assign done      = done_q;

  // The clamp is applied to the captured value so a late change on the
  // prescale input cannot stretch or shrink a frame in flight.
  assign p_eff   = (prescale_q < MIN_PRESCALE) ? MIN_PRESCALE : prescale_q;
  assign bit_end = (pcnt_q == (p_eff - 6'd1));

  // Index of the final byte for the captured command type.
  always_comb begin
    unique case (type_q)
      CMD_RF_WR:   last_byte = 2'd2;
      CMD_RF_RD:   last_byte = 2'd1;
      CMD_ALU_OPS: last_byte = 2'd3;
      default:     last_byte = 2'd1;
    endcase
  end

  // Next-state logic for FSM and counters.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          pcnt_d  = 6'd0;
          bit_d   = 4'd0;
          byte_d  = 2'd0;
        end
      end

      ST_START: begin
        pcnt_d = pcnt_q + 6'd1;
        if (bit_end) begin
          pcnt_d  = 6'd0;
          bit_d   = 4'd0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        pcnt_d = pcnt_q + 6'd1;
        if (bit_end) begin
          pcnt_d = 6'd0;
          if (bit_q == 4'd7) begin
            bit_d   = 4'd0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        pcnt_d = pcnt_q + 6'd1;
        if (bit_end) begin
          pcnt_d  = 6'd0;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        pcnt_d = pcnt_q + 6'd1;
        if (bit_end) begin
          pcnt_d = 6'd0;
          if (byte_q == last_byte) begin
            byte_d  = 2'd0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_START;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        pcnt_d  = 6'd0;
        bit_d   = 4'd0;
        byte_d  = 2'd0;
      end
    endcase
  end

  // Byte that will be on the line in the next cycle. Indexed by byte_d so the
  // registered tx_out already carries the new byte on the first cycle of it.
  always_comb begin
    byte_val = 8'h00;
    unique case (type_q)
      CMD_RF_WR: begin
        unique case (byte_d)
          2'd0:    byte_val = 8'hAA;
          2'd1:    byte_val = {4'h0, addr_q};
          default: byte_val = data0_q;
        endcase
      end
      CMD_RF_RD: begin
        byte_val = (byte_d == 2'd0) ? 8'hBB : {4'h0, addr_q};
      end
      CMD_ALU_OPS: begin
        unique case (byte_d)
          2'd0:    byte_val = 8'hCC;
          2'd1:    byte_val = data0_q;
          2'd2:    byte_val = data1_q;
          default: byte_val = {4'h0, fun_q};
        endcase
      end
      default: begin
        byte_val = (byte_d == 2'd0) ? 8'hDD : {4'h0, fun_q};
      end
    endcase
  end

  // Line value for the next cycle, derived from the next state so that tx_out
  // is a plain flop output and changes exactly on bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = byte_val[bit_d[2:0]];
      ST_PARITY: tx_d = (^byte_val) ^ par_odd_q;
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      pcnt_q  <= 6'd0;
      bit_q   <= 4'd0;
      byte_q  <= 2'd0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  // Command capture; only loads while idle, so a command arriving mid-frame
  // leaves the frame in flight untouched.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      type_q     <= CMD_RF_WR;
      addr_q     <= 4'd0;
      data0_q    <= 8'd0;
      data1_q    <= 8'd0;
      fun_q      <= 4'd0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      prescale_q <= 6'd0;
    end else if (accept) begin
      type_q     <= cmd_type_e'(cmd_type);
      addr_q     <= cmd_addr;
      data0_q    <= cmd_data0;
      data1_q    <= cmd_data1;
      fun_q      <= cmd_fun;
      par_en_q   <= parity_enable;
      par_odd_q  <= parity_type;
      prescale_q <= prescale;
    end
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_tx
//
// Self-checking bench for cmd_frame_tx. Commands push their expected byte
// sequence into a scoreboard queue; the frame checker pops the bytes, expands
// them into the serial bit stream and compares the line cycle by cycle,
// including the done/busy/cmd_ready behaviour after the last stop bit.
// -----------------------------------------------------------------------------
module tb_cmd_frame_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data0;
  logic [7:0] cmd_data1;
  logic [3:0] cmd_fun;
  logic       parity_enable;
  logic       parity_type;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       done;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  cmd_frame_tx dut (
    .CLK           (CLK),
    .RST           (RST),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_type      (cmd_type),
    .cmd_addr      (cmd_addr),
    .cmd_data0     (cmd_data0),
    .cmd_data1     (cmd_data1),
    .cmd_fun       (cmd_fun),
    .parity_enable (parity_enable),
    .parity_type   (parity_type),
    .prescale      (prescale),
    .tx_out        (tx_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int eff_p(input logic [5:0] ps);
    return (ps < 6'd4) ? 4 : int'(ps);
  endfunction

  // Reference byte sequence for one command.
  function automatic void push_expected(input logic [1:0] t, input logic [3:0] a,
                                        input logic [7:0] d0, input logic [7:0] d1,
                                        input logic [3:0] f);
    case (t)
      2'd0: begin exp_q.push_back(8'hAA); exp_q.push_back({4'h0, a}); exp_q.push_back(d0); end
      2'd1: begin exp_q.push_back(8'hBB); exp_q.push_back({4'h0, a}); end
      2'd2: begin
        exp_q.push_back(8'hCC); exp_q.push_back(d0);
        exp_q.push_back(d1);    exp_q.push_back({4'h0, f});
      end
      default: begin exp_q.push_back(8'hDD); exp_q.push_back({4'h0, f}); end
    endcase
  endfunction

  task automatic scramble_inputs();
    cmd_type      = 2'($urandom);
    cmd_addr      = 4'($urandom);
    cmd_data0     = 8'($urandom);
    cmd_data1     = 8'($urandom);
    cmd_fun       = 4'($urandom);
    parity_enable = 1'($urandom);
    parity_type   = 1'($urandom);
    prescale      = 6'($urandom);
  endtask

  // Presents a command for one cycle; after the accepting edge the inputs are
  // scrambled so the frame must come from captured values only.
  task automatic send_cmd(input logic [1:0] t, input logic [3:0] a,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [3:0] f, input logic pe, input logic pt,
                          input logic [5:0] ps);
    @(negedge CLK);
    cmd_type = t; cmd_addr = a; cmd_data0 = d0; cmd_data1 = d1; cmd_fun = f;
    parity_enable = pe; parity_type = pt; prescale = ps;
    cmd_valid = 1'b1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    push_expected(t, a, d0, d1, f);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    scramble_inputs();
  endtask

  // Pops the scoreboard and checks the line from cycle N+1 through N+L+2.
  task automatic check_frame(input string name, input logic pe, input logic pt,
                             input int p, input bit collide);
    bit         bits[$];
    logic [7:0] b;
    bit         bad;
    logic       obs_tx, obs_busy, obs_rdy, obs_done;

    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(b[k]);
      if (pe) bits.push_back((^b) ^ pt);
      bits.push_back(1'b1);
    end

    for (int i = 0; i < bits.size(); i++) begin
      bad = 1'b0;
      obs_tx = 1'b0; obs_busy = 1'b0; obs_rdy = 1'b0; obs_done = 1'b0;
      for (int c = 0; c < p; c++) begin
        @(negedge CLK);
        if (collide && i == 12 && c == 0) begin
          cmd_valid = 1'b1; cmd_type = 2'd3; cmd_fun = 4'hF; cmd_addr = 4'h0;
          cmd_data0 = 8'h00; parity_enable = ~pe; parity_type = ~pt; prescale = 6'd4;
        end
        if (collide && i == 15 && c == 0) cmd_valid = 1'b0;
        if (!bad && (tx_out !== bits[i] || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0)) begin
          bad = 1'b1;
          obs_tx = tx_out; obs_busy = busy; obs_rdy = cmd_ready; obs_done = done;
        end
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL %s_bit%0d: tx/busy/ready/done=%b%b%b%b expected %b100",
                 name, i, obs_tx, obs_busy, obs_rdy, obs_done, bits[i]);
      end
    end

    @(negedge CLK);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || tx_out !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end: done/busy/ready/tx=%b%b%b%b expected 1011",
               name, done, busy, cmd_ready, tx_out);
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: done/busy=%b%b expected 00", name, done, busy);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    cmd_valid = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: tx/busy/done/ready=%b%b%b%b expected 1001",
               tx_out, busy, done, cmd_ready);
    end
    RST = 1'b1;
  endtask

  task automatic test_rf_write();
    send_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 6'd8);
    check_frame("rf_write", 1'b0, 1'b0, 8, 1'b0);
  endtask

  task automatic test_alu_even();
    send_cmd(2'd2, 4'd0, 8'h12, 8'h34, 4'h1, 1'b1, 1'b0, 6'd16);
    check_frame("alu_even", 1'b1, 1'b0, 16, 1'b0);
  endtask

  task automatic test_odd_parity();
    send_cmd(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 6'd32);
    check_frame("rd_odd", 1'b1, 1'b1, 32, 1'b0);
  endtask

  task automatic test_prescale_clamp();
    send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0, 6'd2);
    check_frame("clamp", 1'b0, 1'b0, eff_p(6'd2), 1'b0);
  endtask

  task automatic test_prescale_max();
    send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'hA, 1'b1, 1'b0, 6'd63);
    check_frame("p_max", 1'b1, 1'b0, eff_p(6'd63), 1'b0);
  endtask

  task automatic test_collision();
    send_cmd(2'd0, 4'hA, 8'hC3, 8'h00, 4'h0, 1'b1, 1'b1, 6'd8);
    check_frame("collide", 1'b1, 1'b1, 8, 1'b1);
  endtask

  task automatic test_back_to_back();
    send_cmd(2'd1, 4'h6, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 6'd5);
    check_frame("b2b_a", 1'b0, 1'b0, 5, 1'b0);
    send_cmd(2'd2, 4'h0, 8'hFF, 8'h80, 4'h9, 1'b1, 1'b1, 6'd4);
    check_frame("b2b_b", 1'b1, 1'b1, 4, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    send_cmd(2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0, 6'd8);
    // Byte 2 data bits occupy cycles N+169..N+232.
    repeat (188) @(negedge CLK);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b expected 1", busy);
    end
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: tx/busy/done/ready=%b%b%b%b expected 1001",
               tx_out, busy, done, cmd_ready);
    end
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    send_cmd(2'd1, 4'h9, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 6'd4);
    check_frame("post_reset", 1'b1, 1'b0, 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_rf_write();
    test_alu_even();
    test_odd_parity();
    test_prescale_clamp();
    test_prescale_max();
    test_collision();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_tx.md
CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-002 Port CLK, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-003 Port RST, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port cmd_valid, input, 1 bit: a command is presented.
REQ-005 Port cmd_ready, output, 1 bit: the block can accept a command.
REQ-006 Port cmd_type, input, 2 bits: command type, encoded 0=RF write, 1=RF read, 2=ALU with operands, 3=ALU without operands.
REQ-007 Port cmd_addr, input, 4 bits: register file address.
REQ-008 Port cmd_data0, input, 8 bits: RF write data, or operand A.
REQ-009 Port cmd_data1, input, 8 bits: operand B.
REQ-010 Port cmd_fun, input, 4 bits: ALU function code.
REQ-011 Port parity_enable, input, 1 bit: 1 = a parity bit is inserted after the data bits.
REQ-012 Port parity_type, input, 1 bit: 0 = even parity, 1 = odd parity.
REQ-013 Port prescale, input, 6 bits: CLK cycles per serial bit.
REQ-014 Port tx_out, output, 1 bit: serial UART line; drives the system UART_RX_IN.
REQ-015 Port busy, output, 1 bit: high while a frame is in flight.
REQ-016 Port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-017 A command SHALL be accepted in any cycle where cmd_valid && cmd_ready; cmd_ready SHALL equal !busy.
REQ-018 On acceptance, all command fields, parity_enable, parity_type and prescale SHALL be latched; later changes to these inputs SHALL NOT affect the frame in flight.
REQ-019 A latched prescale value below 4 SHALL be treated as 4.
REQ-020 The byte sequence SHALL depend on cmd_type:
- type 0: 0xAA, {4'h0,addr}, data0
- type 1: 0xBB, {4'h0,addr}
- type 2: 0xCC, data0, data1, {4'h0,fun}
- type 3: 0xDD, {4'h0,fun}
REQ-021 Each byte SHALL be serialized in this order:
- start bit (0)
- 8 data bits, LSB first
- parity bit, only if enabled
- stop bit (1)
REQ-022 Every bit SHALL last exactly P CLK cycles, where P is the effective prescale.
REQ-023 Bytes SHALL be sent back-to-back: the next start bit SHALL follow the previous stop bit with no gap.
REQ-024 Parity SHALL be computed as follows:
- even: parity bit = XOR of the 8 data bits
- odd: parity bit = inverted XOR of the 8 data bits
REQ-025 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-026 The FSM SHALL make these transitions:
- IDLE -> START on acceptance
- START -> DATA after P cycles
- DATA -> PARITY after 8 bits if parity is enabled, otherwise DATA -> STOP
- PARITY -> STOP after P cycles
- STOP -> START if more bytes remain, otherwise STOP -> IDLE
REQ-027 A 4-bit bit counter, a 2-bit byte index and a 6-bit prescale counter SHALL be used.
REQ-028 Every counter SHALL reset to 0 at each bit boundary or byte boundary as appropriate.
REQ-029 Timing relative to acceptance in cycle N:
- busy SHALL be high and tx_out SHALL be 0 (start bit) from cycle N+1
- frame length L = bytes × (10 + parity_enable) × P cycles
- the last stop bit SHALL occupy cycles N+L-P+1 .. N+L
- done SHALL pulse and busy SHALL fall in cycle N+L+1, with cmd_ready high in that same cycle
REQ-030 A command presented while busy SHALL be ignored: no latching occurs and the current frame is unaffected.
REQ-031 tx_out SHALL be registered (glitch-free) and SHALL be 1 whenever the FSM is in IDLE.

Reset
REQ-032 On RST low, the block SHALL immediately reset, including mid-frame:
- tx_out = 1
- busy = 0
- done = 0
- cmd_ready = 1
- FSM = IDLE
- all counters and latched fields = 0
REQ-033 After RST deasserts, the first command SHALL be accepted on the first rising CLK edge with cmd_valid high.
REQ-034 A partially sent frame SHALL NOT be resumed after reset.

Verification
REQ-035 Scenario RF write: type 0, addr 5, data0 0x3C, P=8, parity off -> bytes AA,05,3C; 240 cycles; done at N+241.
REQ-036 Scenario ALU with operands: type 2, data0 0x12, data1 0x34, fun 1, P=16, even parity -> bytes CC,12,34,01; parity bits 0,0,1,1; 704 cycles.
REQ-037 Scenario odd parity: type 1, addr 0xF, P=32, odd parity -> bytes BB,0F; both parity bits = 1.
REQ-038 Scenario prescale clamp: prescale = 2 on a type-3 command -> each bit lasts 4 cycles; 80-cycle frame.
REQ-039 Scenario busy collision: a second cmd_valid with new fields mid-frame -> ignored; line bits are unchanged; exactly one done pulse.
REQ-040 Scenario reset mid-frame: RST low during the DATA bits of byte 2 -> tx_out = 1 and busy = 0 asynchronously; a new command afterwards starts cleanly from byte 0.
